// File: rtl/toggle_activity_monitor_if.sv
// Result stream of toggle_activity_monitor: one beat per monitored net.
//   res_valid : beat valid (producer)
//   res_ready : consumer accepts beat (consumer)
//   res_idx   : net index of the current beat (producer)
//   res_count : toggle count of net res_idx (producer)
//   res_last  : beat carries the highest net index (producer)
interface toggle_activity_monitor_if #(
  parameter int NETS  = 5,
  parameter int CNT_W = 16
);
  localparam int IDX_W = (NETS > 1) ? $clog2(NETS) : 1;

  logic             res_valid;
  logic             res_ready;
  logic [IDX_W-1:0] res_idx;
  logic [CNT_W-1:0] res_count;
  logic             res_last;

  modport master (
    output res_valid, res_idx, res_count, res_last,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_idx, res_count, res_last,
    output res_ready
  );
endinterface

// File: rtl/toggle_activity_monitor.sv
// Switching-activity probe. Samples NETS nets on every enabled cycle of a
// WINDOW-sample measurement, counts per-net toggles in saturating CNT_W-bit
// counters, then streams the counts out one beat per net.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : begin a measurement (honoured only when idle)
//   abort      : return to idle from anywhere, counters cleared
//   en         : sample qualifier; en=0 cycles are ignored
//   net_in     : monitored nets
//   busy       : measurement or report in progress
//   done       : one-cycle pulse after the final beat transfers
//   res        : result stream (valid/ready, idx, count, last)
module toggle_activity_monitor #(
  parameter int NETS   = 5,
  parameter int WINDOW = 256,
  parameter int CNT_W  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            en,
  input  logic [NETS-1:0] net_in,
  output logic            busy,
  output logic            done,
  toggle_activity_monitor_if.master res
);

  localparam int IDX_W = (NETS > 1) ? $clog2(NETS) : 1;
  localparam int WIN_W = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    REPORT
  } state_t;

  state_t state, state_n;

  logic [NETS-1:0]  prev;
  logic [CNT_W-1:0] cnt   [NETS];
  logic [CNT_W-1:0] cnt_n [NETS];
  logic [WIN_W-1:0] win_cnt;

  logic             res_valid_q;
  logic [IDX_W-1:0] res_idx_q;
  logic [CNT_W-1:0] res_count_q;
  logic             res_last_q;

  logic             win_last;
  logic             xfer;
  logic [IDX_W-1:0] idx_nxt;

  assign res.res_valid = res_valid_q;
  assign res.res_idx   = res_idx_q;
  assign res.res_count = res_count_q;
  assign res.res_last  = res_last_q;

  // The enabled sample that brings win_cnt to WINDOW is the last one.
  assign win_last = (win_cnt == WIN_W'(WINDOW - 1));
  assign xfer     = res_valid_q & res.res_ready;
  assign idx_nxt  = res_idx_q + IDX_W'(1);

  // Saturating per-net counter update for the current sample.
  always_comb begin
    for (int unsigned i = 0; i < NETS; i++) begin
      cnt_n[i] = cnt[i];
      if ((net_in[i] != prev[i]) && (cnt[i] != '1)) begin
        cnt_n[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start)             state_n = COLLECT;
        COLLECT: if (en && win_last)    state_n = REPORT;
        REPORT:  if (xfer && res_last_q) state_n = IDLE;
        default:                        state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev        <= '0;
      win_cnt     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_count_q <= '0;
      res_last_q  <= 1'b0;
      for (int unsigned i = 0; i < NETS; i++) cnt[i] <= '0;
    end else begin
      done <= 1'b0;
      busy <= (state_n != IDLE);
      if (abort) begin
        win_cnt     <= '0;
        res_valid_q <= 1'b0;
        res_idx_q   <= '0;
        res_count_q <= '0;
        res_last_q  <= 1'b0;
        for (int unsigned i = 0; i < NETS; i++) cnt[i] <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              prev    <= net_in;
              win_cnt <= '0;
              for (int unsigned i = 0; i < NETS; i++) cnt[i] <= '0;
            end
          end
          COLLECT: begin
            if (en) begin
              prev    <= net_in;
              win_cnt <= win_cnt + WIN_W'(1);
              for (int unsigned i = 0; i < NETS; i++) cnt[i] <= cnt_n[i];
              if (win_last) begin
                // First beat must already include this final sample.
                res_valid_q <= 1'b1;
                res_idx_q   <= '0;
                res_count_q <= cnt_n[0];
                res_last_q  <= (NETS == 1);
              end
            end
          end
          REPORT: begin
            if (xfer) begin
              if (res_last_q) begin
                res_valid_q <= 1'b0;
                res_idx_q   <= '0;
                res_count_q <= '0;
                res_last_q  <= 1'b0;
                done        <= 1'b1;
              end else begin
                res_idx_q   <= idx_nxt;
                res_count_q <= cnt[idx_nxt];
                res_last_q  <= (idx_nxt == IDX_W'(NETS - 1));
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
